// File: rtl/fixed_point_mac_if.sv
// Operand/result bundle for the fixed-point MAC: clock enable, input beat
// qualifiers, operands, and the rounded/saturated result.
interface fixed_point_mac_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic              ce;
  logic              bypass;
  logic              in_valid;
  logic              in_last;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OUT_W-1:0]  s;
  logic              out_valid;
  logic              ovf;

  modport master (output ce, bypass, in_valid, in_last, a, b,
                  input  s, out_valid, ovf);
  modport slave  (input  ce, bypass, in_valid, in_last, a, b,
                  output s, out_valid, ovf);
endinterface

// File: rtl/fixed_point_mac.sv
// Signed fixed-point multiply-accumulate. S1 multiplies, S2 accumulates a
// vector closed by in_last (or forwards a bypass product), S3 rounds half
// toward +inf and saturates to OUT_W bits.
module fixed_point_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16
) (
  input  logic           clk,
  input  logic           sclr_n,
  fixed_point_mac_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  // Rounding constant and saturation bounds, one bit wider than the
  // accumulator so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W:0] SMAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN = ~SMAX;

  // S1 state
  logic signed [PW-1:0]    p_q;
  logic                    v1_q, last1_q, byp1_q;
  // S2 state
  logic signed [ACC_W-1:0] acc_q, acc_d, r_q, r_d;
  logic                    first_q, first_d, rv_q, rv_d;
  // S3 state
  logic [OUT_W-1:0]        s_q, s_d;
  logic                    ovf_q, ovf_d, ov_q;

  logic signed [ACC_W-1:0] p_ext, sum;
  logic signed [ACC_W:0]   rnd, t;

  // S1: capture the full-width product and the beat qualifiers
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      byp1_q  <= 1'b0;
      p_q     <= '0;
    end else if (bus.ce) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        p_q     <= PW'($signed(bus.a)) * PW'($signed(bus.b));
        last1_q <= bus.in_last;
        byp1_q  <= bus.bypass;
      end
    end
  end

  // S2 next state: bypass leaves the open vector untouched; 'first' stands in
  // for clearing the accumulator so a new vector can start with no gap.
  always_comb begin
    p_ext   = ACC_W'(p_q);
    sum     = (first_q ? '0 : acc_q) + p_ext;
    acc_d   = acc_q;
    first_d = first_q;
    r_d     = r_q;
    rv_d    = 1'b0;
    if (v1_q) begin
      if (byp1_q) begin
        r_d  = p_ext;
        rv_d = 1'b1;
      end else if (last1_q) begin
        r_d     = sum;
        rv_d    = 1'b1;
        acc_d   = '0;
        first_d = 1'b1;
      end else begin
        acc_d   = sum;
        first_d = 1'b0;
      end
    end
  end

  // S2 registers
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      acc_q   <= '0;
      first_q <= 1'b1;
      r_q     <= '0;
      rv_q    <= 1'b0;
    end else if (bus.ce) begin
      acc_q   <= acc_d;
      first_q <= first_d;
      r_q     <= r_d;
      rv_q    <= rv_d;
    end
  end

  // S3 next state: round half toward +inf, then clip to the OUT_W range
  always_comb begin
    rnd   = {r_q[ACC_W-1], r_q} + HALF;
    t     = rnd >>> FRAC_W;
    s_d   = t[OUT_W-1:0];
    ovf_d = 1'b0;
    if (t > SMAX) begin
      s_d   = SMAX[OUT_W-1:0];
      ovf_d = 1'b1;
    end else if (t < SMIN) begin
      s_d   = SMIN[OUT_W-1:0];
      ovf_d = 1'b1;
    end
  end

  // S3 registers: result held until the next one, valid pulses one ce-cycle
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      s_q   <= '0;
      ovf_q <= 1'b0;
      ov_q  <= 1'b0;
    end else if (bus.ce) begin
      ov_q <= rv_q;
      if (rv_q) begin
        s_q   <= s_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.s         = s_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_fixed_point_mac.sv
// Bench for fixed_point_mac: directed table of single products, hand-written
// vector sequences, and a randomized run against a queue-based reference.
module tb_fixed_point_mac;
  logic clk = 1'b0;
  logic sclr_n = 1'b0;
  always #5 clk = ~clk;

  fixed_point_mac_if #(.DATA_W(16), .OUT_W(16)) bus ();

  fixed_point_mac #(.DATA_W(16), .FRAC_W(8), .ACC_W(40), .OUT_W(16)) dut (
    .clk(clk), .sclr_n(sclr_n), .bus(bus.slave));

  int passed = 0, total = 0;

  typedef struct { logic [15:0] s; logic ovf; int stamp; } exp_t;
  exp_t exp_q[$];
  longint macc = 0;
  int cecnt = 0;
  logic [15:0] cap_s[$];
  logic        cap_o[$];

  typedef struct { logic [15:0] a, b, s; logic ovf; } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference rounding: floor((r + 0.5 LSB) / 2^8), then clip to 16 bits
  function automatic void rsat(input longint r, output logic [15:0] s, output logic o);
    longint t;
    t = (r + 128) >>> 8;
    o = 1'b0;
    if (t > 32767) begin s = 16'h7FFF; o = 1'b1; end
    else if (t < -32768) begin s = 16'h8000; o = 1'b1; end
    else s = t[15:0];
  endfunction

  // One clock: drive inputs, update the model, check any emitted result
  task automatic cyc(input logic ce_, v, byp, last, input logic [15:0] a_, b_);
    longint ai, bi, p;
    exp_t e;
    bus.ce = ce_; bus.in_valid = v; bus.bypass = byp; bus.in_last = last;
    bus.a = a_; bus.b = b_;
    if (!sclr_n) begin
      exp_q.delete();
      macc = 0;
    end else if (ce_) begin
      cecnt++;
      if (v) begin
        ai = longint'($signed(a_)); bi = longint'($signed(b_));
        p = ai * bi;
        if (byp) begin
          rsat(p, e.s, e.ovf); e.stamp = cecnt + 2; exp_q.push_back(e);
        end else begin
          macc = macc + p;
          macc = (macc <<< 24) >>> 24;
          if (last) begin
            rsat(macc, e.s, e.ovf); e.stamp = cecnt + 2; exp_q.push_back(e);
            macc = 0;
          end
        end
      end
    end
    @(posedge clk); #1;
    if (sclr_n && ce_ && bus.out_valid) begin
      cap_s.push_back(bus.s); cap_o.push_back(bus.ovf);
      if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("model_s", 64'(bus.s), 64'(e.s));
        chk("model_ovf", 64'(bus.ovf), 64'(e.ovf));
        chk("model_latency", 64'(cecnt), 64'(e.stamp));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic beat(input logic byp, last, input logic [15:0] a_, b_);
    cyc(1, 1, byp, last, a_, b_);
  endtask

  int n0;
  logic [15:0] ra, rb;

  initial begin
    tbl[0] = '{16'h0100, 16'h0200, 16'h0200, 1'b0};
    tbl[1] = '{16'h0001, 16'h0080, 16'h0001, 1'b0};
    tbl[2] = '{16'h0001, 16'h007F, 16'h0000, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0};
    tbl[4] = '{16'h0A00, 16'h1400, 16'h7FFF, 1'b1};
    tbl[5] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    tbl[6] = '{16'h0100, 16'h0100, 16'h0100, 1'b0};

    // reset state, with ce low to show reset dominates
    sclr_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 16'h7FFF, 16'h7FFF);
    chk("reset_s", 64'(bus.s), 0);
    chk("reset_out_valid", 64'(bus.out_valid), 0);
    chk("reset_ovf", 64'(bus.ovf), 0);
    sclr_n = 1'b1;
    idle(2);

    // bypass products from the table, each as a single pulse
    for (int i = 0; i < 7; i++) begin
      n0 = cap_s.size();
      beat(1, 0, tbl[i].a, tbl[i].b);
      idle(2);
      chk($sformatf("tbl%0d_count", i), 64'(cap_s.size()), 64'(n0 + 1));
      if (cap_s.size() > n0) begin
        chk($sformatf("tbl%0d_s", i), 64'(cap_s[$]), 64'(tbl[i].s));
        chk($sformatf("tbl%0d_ovf", i), 64'(cap_o[$]), 64'(tbl[i].ovf));
      end
      idle(1);
      chk($sformatf("tbl%0d_pulse", i), 64'(bus.out_valid), 0);
    end

    // three-element vector -> 7.5
    n0 = cap_s.size();
    beat(0, 0, 16'h0100, 16'h0200);
    beat(0, 0, 16'h0300, 16'h0200);
    beat(0, 1, 16'h0080, 16'hFF00);
    idle(3);
    chk("vec_count", 64'(cap_s.size()), 64'(n0 + 1));
    if (cap_s.size() > n0) chk("vec_s", 64'(cap_s[$]), 64'h0780);

    // same vector with ce low mid-vector, and ce low holding the result
    n0 = cap_s.size();
    beat(0, 0, 16'h0100, 16'h0200);
    beat(0, 0, 16'h0300, 16'h0200);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 16'h7FFF, 16'h7FFF);
    beat(0, 1, 16'h0080, 16'hFF00);
    idle(2);
    chk("ce_out_valid", 64'(bus.out_valid), 1);
    cyc(0, 0, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0, 16'h0);
    chk("ce_hold_valid", 64'(bus.out_valid), 1);
    chk("ce_hold_s", 64'(bus.s), 64'h0780);
    idle(1);
    chk("ce_release", 64'(bus.out_valid), 0);
    chk("ce_count", 64'(cap_s.size()), 64'(n0 + 1));

    // bypass beat with in_last inside an open vector
    n0 = cap_s.size();
    beat(0, 0, 16'h0100, 16'h0200);
    beat(1, 1, 16'h0100, 16'h0100);
    beat(0, 0, 16'h0300, 16'h0200);
    beat(0, 1, 16'h0080, 16'hFF00);
    idle(3);
    chk("byp_count", 64'(cap_s.size()), 64'(n0 + 2));
    if (cap_s.size() >= n0 + 2) begin
      chk("byp_first", 64'(cap_s[n0]), 64'h0100);
      chk("byp_vec", 64'(cap_s[n0+1]), 64'h0780);
    end

    // reset mid-vector discards it; next vector is a lone last element
    n0 = cap_s.size();
    beat(0, 0, 16'h0100, 16'h0200);
    beat(0, 0, 16'h0300, 16'h0200);
    sclr_n = 1'b0;
    cyc(1, 1, 0, 1, 16'h0080, 16'hFF00);
    sclr_n = 1'b1;
    idle(4);
    chk("rst_discard", 64'(cap_s.size()), 64'(n0));
    beat(0, 1, 16'h0200, 16'h0200);
    idle(3);
    chk("rst_new_count", 64'(cap_s.size()), 64'(n0 + 1));
    if (cap_s.size() > n0) chk("rst_new_s", 64'(cap_s[$]), 64'h0400);

    // accumulator wraps modulo 2^40: 1024 x 2^30 vanishes
    n0 = cap_s.size();
    for (int i = 0; i < 1024; i++) beat(0, 0, 16'h8000, 16'h8000);
    beat(0, 1, 16'h0100, 16'h0100);
    idle(3);
    chk("wrap_count", 64'(cap_s.size()), 64'(n0 + 1));
    if (cap_s.size() > n0) begin
      chk("wrap_s", 64'(cap_s[$]), 64'h0100);
      chk("wrap_ovf", 64'(cap_o[$]), 0);
    end

    // randomized run, back-to-back vectors, bubbles and ce gaps
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin ra = 16'($urandom); rb = 16'($urandom); end
      else begin
        ra = 16'($urandom_range(0, 2047)) - 16'd1024;
        rb = 16'($urandom_range(0, 2047)) - 16'd1024;
      end
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0, ra, rb);
    end
    beat(0, 1, 16'h0100, 16'h0100);
    idle(4);
    chk("drain_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
